// File: rtl/ps2_note_encoder_pkg.sv
// Shared scancode constants, note/state encodings and the key-lookup record
// for the PS/2 note encoder.
package ps2_note_encoder_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  localparam logic [7:0] SC_C      = 8'h1C;
  localparam logic [7:0] SC_CS     = 8'h1D;
  localparam logic [7:0] SC_D      = 8'h1B;
  localparam logic [7:0] SC_DS     = 8'h24;
  localparam logic [7:0] SC_E      = 8'h23;
  localparam logic [7:0] SC_F      = 8'h2B;
  localparam logic [7:0] SC_FS     = 8'h2C;
  localparam logic [7:0] SC_G      = 8'h34;
  localparam logic [7:0] SC_GS     = 8'h35;
  localparam logic [7:0] SC_A      = 8'h33;
  localparam logic [7:0] SC_AS     = 8'h3C;
  localparam logic [7:0] SC_B      = 8'h3B;
  localparam logic [7:0] SC_C_HI   = 8'h42;
  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;

  localparam logic [2:0] OCT_MIN = 3'd0;
  localparam logic [2:0] OCT_MAX = 3'd7;

  typedef enum logic [3:0] {
    NOTE_C  = 4'd0,
    NOTE_CS = 4'd1,
    NOTE_D  = 4'd2,
    NOTE_DS = 4'd3,
    NOTE_E  = 4'd4,
    NOTE_F  = 4'd5,
    NOTE_FS = 4'd6,
    NOTE_G  = 4'd7,
    NOTE_GS = 4'd8,
    NOTE_A  = 4'd9,
    NOTE_AS = 4'd10,
    NOTE_B  = 4'd11
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic  is_note;
    note_t note;
    logic  oct_inc;
    logic  is_oct_up;
    logic  is_oct_dn;
  } key_info_t;

endpackage

// File: rtl/ps2_note_encoder_if.sv
// Scan-byte input and note-event output bundle of the PS/2 note encoder.
// scan_valid is a one-cycle strobe with no ready: every byte is accepted on the
// cycle it is valid; note_in is a one-cycle event pulse with no backpressure.
interface ps2_note_encoder_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       note_in;
  logic [3:0] note;
  logic [2:0] octave;
  logic [2:0] cur_octave;
  logic       note_held;

  // master: the encoder (consumes bytes, initiates note events)
  modport master (
    input  scan_valid, scan_code,
    output note_in, note, octave, cur_octave, note_held
  );

  // slave: byte source plus note consumer
  modport slave (
    output scan_valid, scan_code,
    input  note_in, note, octave, cur_octave, note_held
  );
endinterface

// File: rtl/ps2_note_encoder_key_lut.sv
// Combinational scancode classifier: note keys, the high-C key and the two
// octave-select keys; everything else decodes to all zeros.
module ps2_note_encoder_key_lut
  import ps2_note_encoder_pkg::*;
(
  input  logic [7:0] code,
  output key_info_t  info
);

  always_comb begin
    info = '0;
    case (code)
      SC_C:      begin info.is_note = 1'b1; info.note = NOTE_C;  end
      SC_CS:     begin info.is_note = 1'b1; info.note = NOTE_CS; end
      SC_D:      begin info.is_note = 1'b1; info.note = NOTE_D;  end
      SC_DS:     begin info.is_note = 1'b1; info.note = NOTE_DS; end
      SC_E:      begin info.is_note = 1'b1; info.note = NOTE_E;  end
      SC_F:      begin info.is_note = 1'b1; info.note = NOTE_F;  end
      SC_FS:     begin info.is_note = 1'b1; info.note = NOTE_FS; end
      SC_G:      begin info.is_note = 1'b1; info.note = NOTE_G;  end
      SC_GS:     begin info.is_note = 1'b1; info.note = NOTE_GS; end
      SC_A:      begin info.is_note = 1'b1; info.note = NOTE_A;  end
      SC_AS:     begin info.is_note = 1'b1; info.note = NOTE_AS; end
      SC_B:      begin info.is_note = 1'b1; info.note = NOTE_B;  end
      // C one octave above the current select
      SC_C_HI:   begin info.is_note = 1'b1; info.note = NOTE_C; info.oct_inc = 1'b1; end
      SC_OCT_UP: info.is_oct_up = 1'b1;
      SC_OCT_DN: info.is_oct_dn = 1'b1;
      default:   info = '0;
    endcase
  end

endmodule

// File: rtl/ps2_note_encoder.sv
// PS/2 set-2 scancode stream to monophonic note events: prefix FSM, octave
// select, held-key tracking and registered note outputs.
module ps2_note_encoder
  import ps2_note_encoder_pkg::*;
#(
  parameter int unsigned DEFAULT_OCTAVE = 4,
  parameter bit          IGNORE_REPEAT  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  ps2_note_encoder_if.master  bus,
  output state_t              fsm_state
);

  localparam logic [2:0] DEF_OCT = 3'(DEFAULT_OCTAVE);

  key_info_t  info;

  state_t     state_q, state_d;
  logic [2:0] cur_oct_q, cur_oct_d;
  logic [3:0] note_q, note_d;
  logic [2:0] oct_q, oct_d;
  logic       held_q, held_d;
  logic [7:0] held_code_q, held_code_d;
  logic       note_in_q, note_in_d;

  logic       high_c_blocked;
  logic       is_repeat;

  ps2_note_encoder_key_lut u_key_lut (
    .code (bus.scan_code),
    .info (info)
  );

  assign high_c_blocked = info.oct_inc && (cur_oct_q == OCT_MAX);
  assign is_repeat      = IGNORE_REPEAT && held_q && (held_code_q == bus.scan_code);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_oct_q   <= DEF_OCT;
      note_q      <= 4'd0;
      oct_q       <= DEF_OCT;
      held_q      <= 1'b0;
      held_code_q <= 8'h00;
      note_in_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_oct_q   <= cur_oct_d;
      note_q      <= note_d;
      oct_q       <= oct_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      note_in_q   <= note_in_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_oct_d   = cur_oct_q;
    note_d      = note_q;
    oct_d       = oct_q;
    held_d      = held_q;
    held_code_d = held_code_q;
    note_in_d   = 1'b0;

    if (bus.scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_code == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (bus.scan_code == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            if (info.is_note && !high_c_blocked && !is_repeat) begin
              note_in_d   = 1'b1;
              note_d      = info.note;
              oct_d       = cur_oct_q + {2'b00, info.oct_inc};
              held_d      = 1'b1;
              held_code_d = bus.scan_code;
            end
            if (info.is_oct_up && cur_oct_q != OCT_MAX) cur_oct_d = cur_oct_q + 3'd1;
            if (info.is_oct_dn && cur_oct_q != OCT_MIN) cur_oct_d = cur_oct_q - 3'd1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          // Only releasing the sounding key ends the note; other releases are stale.
          if (info.is_note && held_q && held_code_q == bus.scan_code) begin
            held_d      = 1'b0;
            held_code_d = 8'h00;
          end
        end
        ST_EXT:     state_d = (bus.scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.note_in    = note_in_q;
  assign bus.note       = note_q;
  assign bus.octave     = oct_q;
  assign bus.cur_octave = cur_oct_q;
  assign bus.note_held  = held_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_ps2_note_encoder.sv
// Directed bench for ps2_note_encoder: byte driver, hand-computed expectations,
// single check task and a one-line report.
module tb_ps2_note_encoder;
  import ps2_note_encoder_pkg::*;

  logic   clk;
  logic   reset;
  state_t fsm_state;
  int     tests_run;
  int     tests_failed;
  int     pulse_cnt;
  logic   pulse;
  int     base;

  ps2_note_encoder_if bus ();

  ps2_note_encoder #(
    .DEFAULT_OCTAVE (4),
    .IGNORE_REPEAT  (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counts cycles with note_in high, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (bus.note_in === 1'b1) pulse_cnt = pulse_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.scan_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // drives one byte for one cycle; returns note_in in the following cycle
  task automatic send_byte(input logic [7:0] code, output logic got_pulse);
    @(negedge clk);
    bus.scan_valid = 1'b1;
    bus.scan_code  = code;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    got_pulse = bus.note_in;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] n, input logic [2:0] o,
                            input logic [2:0] co, input logic h);
    check({tag, ".note"},       32'(bus.note),       32'(n));
    check({tag, ".octave"},     32'(bus.octave),     32'(o));
    check({tag, ".cur_octave"}, 32'(bus.cur_octave), 32'(co));
    check({tag, ".held"},       32'(bus.note_held),  32'(h));
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    pulse_cnt      = 0;
    reset          = 1'b0;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;

    // 1: reset state
    do_reset();
    check("rst.note_in", 32'(bus.note_in), 32'd0);
    check("rst.state", 32'(fsm_state), 32'(ST_IDLE));
    check_outs("rst", 4'd0, 3'd4, 3'd4, 1'b0);

    // 2: make of C, then a typematic repeat
    base = pulse_cnt;
    send_byte(8'h1C, pulse);
    check("c.pulse", 32'(pulse), 32'd1);
    check_outs("c", 4'd0, 3'd4, 3'd4, 1'b1);
    @(negedge clk);
    check("c.pulse_width", 32'(bus.note_in), 32'd0);
    send_byte(8'h1C, pulse);
    check("c_rep.pulse", 32'(pulse), 32'd0);
    @(negedge clk);
    check("c.pulse_cnt", 32'(pulse_cnt - base), 32'd1);

    // 3: break of the held key
    send_byte(8'hF0, pulse);
    check("brk.state", 32'(fsm_state), 32'(ST_BRK));
    send_byte(8'h1C, pulse);
    check("brk.pulse", 32'(pulse), 32'd0);
    check_outs("brk", 4'd0, 3'd4, 3'd4, 1'b0);

    // 4: octave up saturation, high C blocked at 7, octave down after a note
    send_byte(8'h22, pulse); check("up1", 32'(bus.cur_octave), 32'd5);
    send_byte(8'h22, pulse); check("up2", 32'(bus.cur_octave), 32'd6);
    send_byte(8'h22, pulse); check("up3", 32'(bus.cur_octave), 32'd7);
    send_byte(8'h22, pulse); check("up4", 32'(bus.cur_octave), 32'd7);
    send_byte(8'h42, pulse);
    check("hic7.pulse", 32'(pulse), 32'd0);
    check_outs("hic7", 4'd0, 3'd4, 3'd7, 1'b0);
    send_byte(8'h3B, pulse);
    check("b.pulse", 32'(pulse), 32'd1);
    check_outs("b", 4'd11, 3'd7, 3'd7, 1'b1);
    send_byte(8'h1A, pulse);
    check_outs("dn", 4'd11, 3'd7, 3'd6, 1'b1);

    // 5: last-note priority and stale break
    send_byte(8'h1C, pulse);
    check("c6.pulse", 32'(pulse), 32'd1);
    check_outs("c6", 4'd0, 3'd6, 3'd6, 1'b1);
    send_byte(8'h33, pulse);
    check("a.pulse", 32'(pulse), 32'd1);
    check_outs("a", 4'd9, 3'd6, 3'd6, 1'b1);
    send_byte(8'hF0, pulse);
    send_byte(8'h1C, pulse);
    check("stale_brk.held", 32'(bus.note_held), 32'd1);
    send_byte(8'hF0, pulse);
    send_byte(8'h33, pulse);
    check_outs("a_brk", 4'd9, 3'd6, 3'd6, 1'b0);

    // 6: extended keys are dropped; extended break also dropped
    send_byte(8'hE0, pulse);
    check("ext.state", 32'(fsm_state), 32'(ST_EXT));
    send_byte(8'h1C, pulse);
    check("ext.pulse", 32'(pulse), 32'd0);
    check("ext.state_back", 32'(fsm_state), 32'(ST_IDLE));
    send_byte(8'hE0, pulse);
    send_byte(8'hF0, pulse);
    check("extbrk.state", 32'(fsm_state), 32'(ST_EXT_BRK));
    send_byte(8'h1C, pulse);
    check("extbrk.pulse", 32'(pulse), 32'd0);
    check_outs("extbrk", 4'd9, 3'd6, 3'd6, 1'b0);
    send_byte(8'h15, pulse);
    check("unmapped.pulse", 32'(pulse), 32'd0);

    // prefix discarded by reset
    send_byte(8'hF0, pulse);
    do_reset();
    check("rst_prefix.state", 32'(fsm_state), 32'(ST_IDLE));
    send_byte(8'h1C, pulse);
    check("rst_prefix.pulse", 32'(pulse), 32'd1);
    check_outs("rst_prefix", 4'd0, 3'd4, 3'd4, 1'b1);

    // octave down saturation, then high C from octave 0
    send_byte(8'h1A, pulse); check("dn1", 32'(bus.cur_octave), 32'd3);
    send_byte(8'h1A, pulse); check("dn2", 32'(bus.cur_octave), 32'd2);
    send_byte(8'h1A, pulse); check("dn3", 32'(bus.cur_octave), 32'd1);
    send_byte(8'h1A, pulse); check("dn4", 32'(bus.cur_octave), 32'd0);
    send_byte(8'h1A, pulse); check("dn5", 32'(bus.cur_octave), 32'd0);
    send_byte(8'h42, pulse);
    check("hic0.pulse", 32'(pulse), 32'd1);
    check_outs("hic0", 4'd0, 3'd1, 3'd0, 1'b1);
    send_byte(8'hF0, pulse);
    send_byte(8'h42, pulse);
    check("hic0_brk.held", 32'(bus.note_held), 32'd0);

    // back-to-back bytes on consecutive cycles
    @(negedge clk);
    base = pulse_cnt;
    bus.scan_valid = 1'b1;
    bus.scan_code  = 8'h1C;
    @(negedge clk);
    bus.scan_code  = 8'h33;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    @(negedge clk);
    check("b2b.pulse_cnt", 32'(pulse_cnt - base), 32'd2);
    check_outs("b2b", 4'd9, 3'd0, 3'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
